// File: rtl/match_controller.sv
// Best-of-N two-fighter match controller: countdown, timed rounds, pause,
// shield/iframe-filtered HP and per-round win tally. All outputs registered.
module match_controller #(
  parameter int unsigned HP_WIDTH        = 2,
  parameter int unsigned MAX_HP          = 3,
  parameter int unsigned WIN_WIDTH       = 2,
  parameter int unsigned ROUNDS_TO_WIN   = 2,
  parameter int unsigned TIMER_WIDTH     = 7,
  parameter int unsigned COUNTDOWN_TICKS = 3,
  parameter int unsigned ROUND_TICKS     = 60,
  parameter int unsigned IFRAME_TICKS    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic                   select,
  input  logic                   pause,
  input  logic                   player_hit,
  input  logic                   enemy_hit,
  input  logic                   player_shield,
  input  logic                   enemy_shield,
  output logic [2:0]             o_state,
  output logic [HP_WIDTH-1:0]    o_player_hp,
  output logic [HP_WIDTH-1:0]    o_enemy_hp,
  output logic [WIN_WIDTH-1:0]   o_player_wins,
  output logic [WIN_WIDTH-1:0]   o_enemy_wins,
  output logic [TIMER_WIDTH-1:0] o_timer,
  output logic                   o_round_start,
  output logic                   o_play_en
);

  localparam logic [2:0] StStart     = 3'd0;
  localparam logic [2:0] StCountdown = 3'd1;
  localparam logic [2:0] StPlay      = 3'd2;
  localparam logic [2:0] StPause     = 3'd3;
  localparam logic [2:0] StRoundEnd  = 3'd4;
  localparam logic [2:0] StWin       = 3'd5;
  localparam logic [2:0] StLose      = 3'd6;

  localparam int unsigned IfW = (IFRAME_TICKS > 0) ? $clog2(IFRAME_TICKS + 1) : 1;

  localparam logic [HP_WIDTH-1:0]    HpFull        = HP_WIDTH'(MAX_HP);
  localparam logic [WIN_WIDTH-1:0]   WinsMax       = WIN_WIDTH'(ROUNDS_TO_WIN);
  localparam logic [TIMER_WIDTH-1:0] CountdownLoad = TIMER_WIDTH'(COUNTDOWN_TICKS);
  localparam logic [TIMER_WIDTH-1:0] RoundLoad     = TIMER_WIDTH'(ROUND_TICKS);
  localparam logic [TIMER_WIDTH-1:0] TimerOne      = TIMER_WIDTH'(1);
  localparam logic [IfW-1:0]         IframeLoad    = IfW'(IFRAME_TICKS);

  logic [2:0]             state_q, state_d;
  logic [HP_WIDTH-1:0]    php_q, php_d, ehp_q, ehp_d;
  logic [WIN_WIDTH-1:0]   pwin_q, pwin_d, ewin_q, ewin_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [IfW-1:0]         pif_q, pif_d, eif_q, eif_d;
  logic                   round_start_q, round_start_d;
  logic                   play_en_q;
  logic                   select_q, pause_q;
  logic                   select_edge, pause_edge;
  logic                   player_out, enemy_out, timed_out;
  logic                   player_takes, enemy_takes;
  logic                   start_round;

  assign select_edge = select & ~select_q;
  assign pause_edge  = pause & ~pause_q;

  assign player_out = (php_q == '0);
  assign enemy_out  = (ehp_q == '0);
  assign timed_out  = ~player_out & ~enemy_out;

  // Double KO and equal-HP timeout both fall through as draws.
  assign player_takes = (enemy_out & ~player_out) | (timed_out & (php_q > ehp_q));
  assign enemy_takes  = (player_out & ~enemy_out) | (timed_out & (ehp_q > php_q));

  always_comb begin
    state_d       = state_q;
    php_d         = php_q;
    ehp_d         = ehp_q;
    pwin_d        = pwin_q;
    ewin_d        = ewin_q;
    timer_d       = timer_q;
    pif_d         = pif_q;
    eif_d         = eif_q;
    round_start_d = 1'b0;
    start_round   = 1'b0;

    case (state_q)
      StStart: begin
        if (select_edge) begin
          pwin_d      = '0;
          ewin_d      = '0;
          start_round = 1'b1;
        end
      end
      StCountdown: begin
        if (frame_tick) begin
          if (timer_q == TimerOne) begin
            state_d = StPlay;
            timer_d = RoundLoad;
          end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      StPlay: begin
        // Exit is decided on registered HP/timer, so a fatal hit ends the round next cycle.
        if (player_out || enemy_out || timer_q == '0) begin
          state_d = StRoundEnd;
          if (player_takes && pwin_q < WinsMax) pwin_d = pwin_q + 1'b1;
          if (enemy_takes && ewin_q < WinsMax) ewin_d = ewin_q + 1'b1;
        end else if (pause_edge) begin
          state_d = StPause;
        end else begin
          if (frame_tick) begin
            if (timer_q != '0) timer_d = timer_q - 1'b1;
            if (pif_q != '0) pif_d = pif_q - 1'b1;
            if (eif_q != '0) eif_d = eif_q - 1'b1;
          end
          // A landed hit reloads the iframe counter, overriding a same-cycle decrement.
          if (player_hit && !player_shield && pif_q == '0) begin
            php_d = php_q - 1'b1;
            pif_d = IframeLoad;
          end
          if (enemy_hit && !enemy_shield && eif_q == '0) begin
            ehp_d = ehp_q - 1'b1;
            eif_d = IframeLoad;
          end
        end
      end
      StPause: begin
        if (pause_edge) state_d = StPlay;
      end
      StRoundEnd: begin
        if (select_edge) begin
          if (pwin_q == WinsMax) begin
            state_d = StWin;
          end else if (ewin_q == WinsMax) begin
            state_d = StLose;
          end else begin
            start_round = 1'b1;
          end
        end
      end
      StWin, StLose: begin
        if (select_edge) state_d = StStart;
      end
      default: state_d = StStart;
    endcase

    if (start_round) begin
      state_d       = StCountdown;
      php_d         = HpFull;
      ehp_d         = HpFull;
      pif_d         = '0;
      eif_d         = '0;
      timer_d       = CountdownLoad;
      round_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StStart;
      php_q         <= HpFull;
      ehp_q         <= HpFull;
      pwin_q        <= '0;
      ewin_q        <= '0;
      timer_q       <= '0;
      pif_q         <= '0;
      eif_q         <= '0;
      round_start_q <= 1'b0;
      play_en_q     <= 1'b0;
      select_q      <= 1'b0;
      pause_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      php_q         <= php_d;
      ehp_q         <= ehp_d;
      pwin_q        <= pwin_d;
      ewin_q        <= ewin_d;
      timer_q       <= timer_d;
      pif_q         <= pif_d;
      eif_q         <= eif_d;
      round_start_q <= round_start_d;
      play_en_q     <= (state_d == StPlay);
      select_q      <= select;
      pause_q       <= pause;
    end
  end

  assign o_state       = state_q;
  assign o_player_hp   = php_q;
  assign o_enemy_hp    = ehp_q;
  assign o_player_wins = pwin_q;
  assign o_enemy_wins  = ewin_q;
  assign o_timer       = timer_q;
  assign o_round_start = round_start_q;
  assign o_play_en     = play_en_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed match scenarios plus a random soak
// compared cycle-by-cycle with a behavioural match model.
module tb_match_controller;

  localparam int MAXHP = 3, RTW = 2, CDT = 3, RT = 60, IFT = 2;
  localparam int S_START = 0, S_CD = 1, S_PLAY = 2, S_PAUSE = 3, S_RE = 4, S_WIN = 5, S_LOSE = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_tick = 0, select = 0, pause = 0, player_hit = 0, enemy_hit = 0;
  logic player_shield = 0, enemy_shield = 0;
  logic [2:0] o_state;
  logic [1:0] o_player_hp, o_enemy_hp, o_player_wins, o_enemy_wins;
  logic [6:0] o_timer;
  logic       o_round_start, o_play_en;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  match_controller #(
    .HP_WIDTH(2), .MAX_HP(MAXHP), .WIN_WIDTH(2), .ROUNDS_TO_WIN(RTW), .TIMER_WIDTH(7),
    .COUNTDOWN_TICKS(CDT), .ROUND_TICKS(RT), .IFRAME_TICKS(IFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .select(select), .pause(pause),
    .player_hit(player_hit), .enemy_hit(enemy_hit), .player_shield(player_shield),
    .enemy_shield(enemy_shield), .o_state(o_state), .o_player_hp(o_player_hp),
    .o_enemy_hp(o_enemy_hp), .o_player_wins(o_player_wins), .o_enemy_wins(o_enemy_wins),
    .o_timer(o_timer), .o_round_start(o_round_start), .o_play_en(o_play_en)
  );

  // Behavioural match model
  int m_state, m_php, m_ehp, m_pw, m_ew, m_timer, m_pi, m_ei;
  bit m_rs, m_sel_prev, m_pause_prev;

  function automatic int dec(input int x);
    return (x > 0) ? x - 1 : 0;
  endfunction

  task automatic model_reset();
    m_state = S_START; m_php = MAXHP; m_ehp = MAXHP; m_pw = 0; m_ew = 0;
    m_timer = 0; m_pi = 0; m_ei = 0; m_rs = 0; m_sel_prev = 0; m_pause_prev = 0;
  endtask

  task automatic model_new_round();
    m_state = S_CD; m_php = MAXHP; m_ehp = MAXHP; m_pi = 0; m_ei = 0;
    m_timer = CDT; m_rs = 1;
  endtask

  task automatic model_clock(input bit s, p, ft, ph, eh, ps, es);
    bit se, pe, p_lands, e_lands;
    int diff;
    se = s && !m_sel_prev;
    pe = p && !m_pause_prev;
    m_sel_prev = s;
    m_pause_prev = p;
    m_rs = 0;
    case (m_state)
      S_START: if (se) begin m_pw = 0; m_ew = 0; model_new_round(); end
      S_CD: if (ft) begin
        if (m_timer == 1) begin m_state = S_PLAY; m_timer = RT; end
        else m_timer = dec(m_timer);
      end
      S_PLAY: begin
        if (m_php == 0 || m_ehp == 0 || m_timer == 0) begin
          // Whoever holds more HP takes the round; equal (incl. 0/0) is a draw.
          diff = m_php - m_ehp;
          if (diff > 0 && m_pw < RTW) m_pw++;
          if (diff < 0 && m_ew < RTW) m_ew++;
          m_state = S_RE;
        end else if (pe) begin
          m_state = S_PAUSE;
        end else begin
          p_lands = ph && !ps && m_pi == 0;
          e_lands = eh && !es && m_ei == 0;
          if (ft) begin m_timer = dec(m_timer); m_pi = dec(m_pi); m_ei = dec(m_ei); end
          if (p_lands) begin m_php = dec(m_php); m_pi = IFT; end
          if (e_lands) begin m_ehp = dec(m_ehp); m_ei = IFT; end
        end
      end
      S_PAUSE: if (pe) m_state = S_PLAY;
      S_RE: if (se) begin
        if (m_pw == RTW) m_state = S_WIN;
        else if (m_ew == RTW) m_state = S_LOSE;
        else model_new_round();
      end
      default: if (se) m_state = S_START;
    endcase
  endtask

  function automatic logic [19:0] model_vec();
    return {3'(m_state), 2'(m_php), 2'(m_ehp), 2'(m_pw), 2'(m_ew), 7'(m_timer), m_rs,
            m_state == S_PLAY};
  endfunction

  task automatic step(input bit s, p, ft, ph, eh, ps, es);
    select = s; pause = p; frame_tick = ft; player_hit = ph; enemy_hit = eh;
    player_shield = ps; enemy_shield = es;
    @(posedge clk);
    model_clock(s, p, ft, ph, eh, ps, es);
    #1;
  endtask

  task automatic tick();         step(0, 0, 1, 0, 0, 0, 0); endtask
  task automatic idle();         step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic press_select(); step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic hit_enemy();    step(0, 0, 0, 0, 1, 0, 0); endtask
  task automatic hit_player();   step(0, 0, 0, 1, 0, 0, 0); endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({o_state, o_player_hp, o_enemy_hp, o_player_wins, o_enemy_wins} !== {3'd0, 2'd3, 2'd3,
        2'd0, 2'd0}) begin
      mismatched++;
      $display("FAIL reset_state: got st=%0d hp=%0d/%0d wins=%0d/%0d want st=0 hp=3/3 wins=0/0",
               o_state, o_player_hp, o_enemy_hp, o_player_wins, o_enemy_wins);
    end
    compared++;
    if ({o_timer, o_round_start, o_play_en} !== 9'd0) begin
      mismatched++;
      $display("FAIL reset_misc: got timer=%0d rs=%0d pe=%0d want 0/0/0",
               o_timer, o_round_start, o_play_en);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_countdown();
    int pulses = 0;
    // Select held high across the whole countdown must not chain.
    step(1, 0, 0, 0, 0, 0, 0);
    if (o_round_start) pulses++;
    compared++;
    if (o_state !== 3'(S_CD) || o_timer !== 7'd3) begin
      mismatched++;
      $display("FAIL cd_enter: got st=%0d timer=%0d want st=1 timer=3", o_state, o_timer);
    end
    for (int i = 0; i < CDT; i++) begin
      step(1, 0, 1, 0, 0, 0, 0);
      if (o_round_start) pulses++;
    end
    compared++;
    if (o_state !== 3'(S_PLAY) || o_timer !== 7'd60 || o_play_en !== 1'b1) begin
      mismatched++;
      $display("FAIL cd_to_play: got st=%0d timer=%0d pe=%0d want st=2 timer=60 pe=1",
               o_state, o_timer, o_play_en);
    end
    idle();
    if (o_round_start) pulses++;
    compared++;
    if (pulses !== 1) begin
      mismatched++;
      $display("FAIL round_start_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_enemy_ko();
    for (int k = 0; k < 3; k++) begin
      hit_enemy();
      compared++;
      if (o_enemy_hp !== 2'(2 - k)) begin
        mismatched++;
        $display("FAIL ko_hp%0d: got %0d want %0d", k, o_enemy_hp, 2 - k);
      end
      if (k < 2) repeat (IFT) tick();
    end
    compared++;
    if (o_state !== 3'(S_PLAY)) begin
      mismatched++;
      $display("FAIL ko_latency: got st=%0d want 2", o_state);
    end
    idle();
    compared++;
    if (o_state !== 3'(S_RE) || o_player_wins !== 2'd1 || o_enemy_wins !== 2'd0) begin
      mismatched++;
      $display("FAIL ko_award: got st=%0d wins=%0d/%0d want st=4 wins=1/0",
               o_state, o_player_wins, o_enemy_wins);
    end
  endtask

  task automatic test_iframe_shield();
    press_select();
    compared++;
    if (o_state !== 3'(S_CD) || o_enemy_hp !== 2'd3 || o_round_start !== 1'b1) begin
      mismatched++;
      $display("FAIL next_round: got st=%0d ehp=%0d rs=%0d want 1/3/1",
               o_state, o_enemy_hp, o_round_start);
    end
    repeat (CDT) tick();
    hit_enemy();
    tick();
    hit_enemy();
    compared++;
    if (o_enemy_hp !== 2'd2) begin
      mismatched++;
      $display("FAIL iframe_block: got ehp=%0d want 2", o_enemy_hp);
    end
    tick();
    step(0, 0, 0, 0, 1, 0, 1);
    compared++;
    if (o_enemy_hp !== 2'd2) begin
      mismatched++;
      $display("FAIL shield_block: got ehp=%0d want 2", o_enemy_hp);
    end
  endtask

  task automatic test_double_ko();
    hit_enemy();
    hit_player();
    repeat (IFT) tick();
    hit_player();
    repeat (IFT) tick();
    step(0, 0, 0, 1, 1, 0, 0);
    compared++;
    if (o_player_hp !== 2'd0 || o_enemy_hp !== 2'd0) begin
      mismatched++;
      $display("FAIL double_hit: got hp=%0d/%0d want 0/0", o_player_hp, o_enemy_hp);
    end
    idle();
    compared++;
    if (o_state !== 3'(S_RE) || o_player_wins !== 2'd1 || o_enemy_wins !== 2'd0) begin
      mismatched++;
      $display("FAIL draw_award: got st=%0d wins=%0d/%0d want st=4 wins=1/0",
               o_state, o_player_wins, o_enemy_wins);
    end
  endtask

  task automatic test_pause();
    press_select();
    repeat (CDT) tick();
    repeat (20) tick();
    step(0, 1, 0, 0, 0, 0, 0);
    compared++;
    if (o_state !== 3'(S_PAUSE) || o_timer !== 7'd40) begin
      mismatched++;
      $display("FAIL pause_enter: got st=%0d timer=%0d want 3/40", o_state, o_timer);
    end
    for (int i = 0; i < 10; i++) step(i == 3, 1, 1, 1, 1, 0, 0);
    idle();
    compared++;
    if (o_state !== 3'(S_PAUSE) || o_timer !== 7'd40 || o_player_hp !== 2'd3 ||
        o_enemy_hp !== 2'd3) begin
      mismatched++;
      $display("FAIL pause_frozen: got st=%0d timer=%0d hp=%0d/%0d want 3/40/3/3",
               o_state, o_timer, o_player_hp, o_enemy_hp);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    tick();
    compared++;
    if (o_state !== 3'(S_PLAY) || o_timer !== 7'd39) begin
      mismatched++;
      $display("FAIL pause_resume: got st=%0d timer=%0d want 2/39", o_state, o_timer);
    end
  endtask

  task automatic test_win_flow();
    for (int k = 0; k < 3; k++) begin
      hit_enemy();
      repeat (IFT) tick();
    end
    idle();
    compared++;
    if (o_state !== 3'(S_RE) || o_player_wins !== 2'd2) begin
      mismatched++;
      $display("FAIL second_win: got st=%0d pwins=%0d want 4/2", o_state, o_player_wins);
    end
    press_select();
    compared++;
    if (o_state !== 3'(S_WIN)) begin
      mismatched++;
      $display("FAIL to_win: got st=%0d want 5", o_state);
    end
    idle();
    press_select();
    compared++;
    if (o_state !== 3'(S_START) || o_player_wins !== 2'd2) begin
      mismatched++;
      $display("FAIL win_to_start: got st=%0d pwins=%0d want 0/2", o_state, o_player_wins);
    end
    idle();
    press_select();
    compared++;
    if (o_state !== 3'(S_CD) || o_player_wins !== 2'd0) begin
      mismatched++;
      $display("FAIL wins_cleared: got st=%0d pwins=%0d want 1/0", o_state, o_player_wins);
    end
    repeat (CDT + 5) tick();
    hit_player();
    rst_n = 1'b0;
    #1;
    model_reset();
    compared++;
    if (o_state !== 3'(S_START) || o_player_hp !== 2'd3 || o_timer !== 7'd0 ||
        o_play_en !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_play_reset: got st=%0d php=%0d timer=%0d pe=%0d want 0/3/0/0",
               o_state, o_player_hp, o_timer, o_play_en);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [19:0] want;
    for (int i = 0; i < 6000; i++) begin
      if (i % 2000 == 1999) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      want = model_vec();
      compared++;
      if ({o_state, o_player_hp, o_enemy_hp, o_player_wins, o_enemy_wins, o_timer,
           o_round_start, o_play_en} !== want) begin
        mismatched++;
        $display("FAIL random_cycle%0d: got %h want %h", i,
                 {o_state, o_player_hp, o_enemy_hp, o_player_wins, o_enemy_wins, o_timer,
                  o_round_start, o_play_en}, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_enemy_ko();
    test_iframe_shield();
    test_double_ko();
    test_pause();
    test_win_flow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
